param_alu: RTL and testbench

PARAM_ALU -- requirements
Module: param_alu

---
 rtl/param_alu_if.sv | 28 ++
 rtl/param_alu.sv | 141 ++++++++++++++
 tb/tb_param_alu.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/param_alu_if.sv
// Request/response bundle for param_alu: a valid/ready request channel
// carrying opcode and operands, and a valid/ready result channel.
interface param_alu_if #(
    parameter int WIDTH = 8
);
    localparam int SW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SW-1:0]    shamt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [7:0]       flags;

    modport master (
        output in_valid, opcode, a, b, shamt, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, opcode, a, b, shamt, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/param_alu.sv
// Parameterised ALU: single-cycle add/sub/logic ops, bit-serial shifts and
// rotates, with a registered result and flag byte held until consumed.
module param_alu #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    param_alu_if.slave   bus
);
    localparam int SW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           next_state;

    logic [WIDTH-1:0] result_q;
    logic [7:0]       flags_q;
    logic [SW-1:0]    count;
    logic [WIDTH-1:0] work;
    logic [1:0]       shift_op;

    logic             accept;
    logic             start_shift;
    logic             last_step;
    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [WIDTH-1:0] step_w;
    logic             step_c;

    function automatic logic [7:0] make_flags(input logic [WIDTH-1:0] r,
                                              input logic c, input logic v);
        logic z;
        logic s;
        z = (r == '0);
        s = r[WIDTH-1];
        return {1'b0, 1'b1, s | z, c & ~z, z, s, v, c};
    endfunction

    assign accept      = bus.in_valid && (state == IDLE);
    assign start_shift = accept && bus.opcode[2] && (bus.shamt != '0);
    assign last_step   = (count == SW'(1));

    // Shift/rotate opcodes fall into the default arm: with shamt=0 they
    // complete at accept with result=b and carry=0, like any single-cycle op.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case statements can infer a latch.
        is_sub  = (bus.opcode == 4'b1000);
        b_eff   = is_sub ? ~bus.b : bus.b;
        sum     = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
        alu_res = bus.b;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (bus.opcode[2:0])
            3'b000: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (bus.a[WIDTH-1] == b_eff[WIDTH-1]) &&
                          (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            3'b001:  alu_res = bus.a ^ bus.b;
            3'b010:  alu_res = bus.a & bus.b;
            3'b011:  alu_res = bus.opcode[3] ? ~(bus.a | bus.b) : (bus.a | bus.b);
            default: alu_res = bus.b;
        endcase
    end

    always_comb begin
        step_w = work;
        step_c = 1'b0;
        case (shift_op)
            2'b00:   {step_c, step_w} = {work, 1'b0};
            2'b01:   {step_w, step_c} = {1'b0, work};
            2'b10:   step_w = {work[WIDTH-2:0], work[WIDTH-1]};
            default: step_w = {work[0], work[WIDTH-1:1]};
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = start_shift ? SHIFT : DONE;
            SHIFT:   if (last_step) next_state = DONE;
            DONE:    if (bus.out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            flags_q  <= 8'h40;
            count    <= '0;
        end else if (accept) begin
            if (start_shift) begin
                count <= bus.shamt;
            end else begin
                result_q <= alu_res;
                flags_q  <= make_flags(alu_res, alu_c, alu_v);
            end
        end else if (state == SHIFT) begin
            count <= count - SW'(1);
            if (last_step) begin
                result_q <= step_w;
                flags_q  <= make_flags(step_w, step_c, 1'b0);
            end
        end
    end

    // NOTE: the working register and shift selector are always loaded at
    // accept before they are read, so they carry no reset.
    always_ff @(posedge clk) begin
        if (start_shift) begin
            work     <= bus.b;
            shift_op <= bus.opcode[1:0];
        end else if (state == SHIFT) begin
            work <= step_w;
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;
endmodule

// File: tb/tb_param_alu.sv
// Self-checking bench for param_alu at WIDTH=8 and WIDTH=13: directed vectors,
// backpressure and reset corner cases, and randomised ops against a model.
module tb_param_alu;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    param_alu_if #(.WIDTH(8))  bus8();
    param_alu_if #(.WIDTH(13)) bus13();

    param_alu #(.WIDTH(8))  u_alu8  (.clk(clk), .rst(rst), .bus(bus8));
    param_alu #(.WIDTH(13)) u_alu13 (.clk(clk), .rst(rst), .bus(bus13));

    // Common stimulus steered to one instance by sel (0: WIDTH=8, 1: WIDTH=13)
    logic        sel;
    logic        in_valid_t;
    logic        out_ready_t;
    logic [3:0]  opcode_t;
    logic [31:0] a_t;
    logic [31:0] b_t;
    logic [3:0]  shamt_t;

    assign bus8.in_valid   = in_valid_t & ~sel;
    assign bus8.out_ready  = out_ready_t & ~sel;
    assign bus8.opcode     = opcode_t;
    assign bus8.a          = a_t[7:0];
    assign bus8.b          = b_t[7:0];
    assign bus8.shamt      = shamt_t[2:0];
    assign bus13.in_valid  = in_valid_t & sel;
    assign bus13.out_ready = out_ready_t & sel;
    assign bus13.opcode    = opcode_t;
    assign bus13.a         = a_t[12:0];
    assign bus13.b         = b_t[12:0];
    assign bus13.shamt     = shamt_t;

    logic        cur_in_ready;
    logic        cur_out_valid;
    logic [31:0] cur_result;
    logic [7:0]  cur_flags;

    assign cur_in_ready  = sel ? bus13.in_ready  : bus8.in_ready;
    assign cur_out_valid = sel ? bus13.out_valid : bus8.out_valid;
    assign cur_result    = sel ? {19'd0, bus13.result} : {24'd0, bus8.result};
    assign cur_flags     = sel ? bus13.flags : bus8.flags;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain arithmetic on the operation's definition.
    function automatic void model(input int w, input logic [3:0] op,
                                  input logic [31:0] a, input logic [31:0] b, input int sh,
                                  output logic [31:0] r, output logic [7:0] f, output int lat);
        longint unsigned mask, ua, ub, res;
        longint sa, sb, sres, smax, smin;
        logic c, v, z, s;
        int k;
        mask = (64'd1 << w) - 1;
        ua   = a & mask;
        ub   = b & mask;
        sa   = ((ua >> (w - 1)) & 1) != 0 ? longint'(ua) - longint'(mask + 1) : longint'(ua);
        sb   = ((ub >> (w - 1)) & 1) != 0 ? longint'(ub) - longint'(mask + 1) : longint'(ub);
        smax = (longint'(1) << (w - 1)) - 1;
        smin = -(longint'(1) << (w - 1));
        c = 1'b0; v = 1'b0; res = 0; lat = 1;
        case (op[2:0])
            3'd0: begin
                if (op[3]) begin
                    res  = (ua - ub) & mask;
                    c    = (ua >= ub);
                    sres = sa - sb;
                end else begin
                    res  = (ua + ub) & mask;
                    c    = ((ua + ub) >> w) != 0;
                    sres = sa + sb;
                end
                v = (sres > smax) || (sres < smin);
            end
            3'd1: res = ua ^ ub;
            3'd2: res = ua & ub;
            3'd3: res = op[3] ? (~(ua | ub)) & mask : (ua | ub);
            3'd4: begin
                if (sh == 0)     res = ub;
                else if (sh > w) res = 0;
                else begin
                    res = (ub << sh) & mask;
                    c   = ((ub >> (w - sh)) & 1) != 0;
                end
            end
            3'd5: begin
                if (sh == 0)     res = ub;
                else if (sh > w) res = 0;
                else begin
                    res = ub >> sh;
                    c   = ((ub >> (sh - 1)) & 1) != 0;
                end
            end
            default: begin
                k = sh % w;
                if (op[0]) res = ((ub >> k) | (ub << (w - k))) & mask;
                else       res = ((ub << k) | (ub >> (w - k))) & mask;
            end
        endcase
        if (op[2] && sh > 0) lat = sh + 1;
        r = 32'(res);
        z = (res == 0);
        s = ((res >> (w - 1)) & 1) != 0;
        f = {1'b0, 1'b1, s | z, c & ~z, z, s, v, c};
    endfunction

    // Accept one request, scramble inputs, measure latency, check, then consume.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int sh, input logic [31:0] exp_r,
                          input logic [7:0] exp_f, input int exp_lat);
        int lat;
        @(negedge clk);
        check({tag, " in_ready"}, 32'(cur_in_ready), 32'd1);
        opcode_t   = op;
        a_t        = a;
        b_t        = b;
        shamt_t    = 4'(sh);
        in_valid_t = 1'b1;
        @(negedge clk);
        in_valid_t = 1'b0;
        opcode_t   = 4'($urandom);
        a_t        = $urandom;
        b_t        = $urandom;
        shamt_t    = 4'($urandom);
        lat = 1;
        while (!cur_out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, cur_result, exp_r);
        check({tag, " flags"}, 32'(cur_flags), 32'(exp_f));
        if (!cur_out_valid) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end else begin
            out_ready_t = 1'b1;
            @(negedge clk);
            out_ready_t = 1'b0;
            check({tag, " released"}, 32'(cur_out_valid), 32'd0);
        end
    endtask

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        int         sh;
        logic [7:0] r;
        logic [7:0] f;
        int         lat;
    } vec_t;

    vec_t vecs[15];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] er;
        logic [7:0]  ef;
        int          el;
        logic [3:0]  op;
        logic [31:0] ra, rb;
        int          sh, w, saw;

        vecs[0]  = '{4'b0000, 8'h7F, 8'h01, 0, 8'h80, 8'h66, 1};
        vecs[1]  = '{4'b1000, 8'h05, 8'h05, 0, 8'h00, 8'h69, 1};
        vecs[2]  = '{4'b1011, 8'hF0, 8'h0F, 0, 8'h00, 8'h68, 1};
        vecs[3]  = '{4'b0100, 8'h00, 8'h81, 1, 8'h02, 8'h51, 2};
        vecs[4]  = '{4'b0111, 8'h00, 8'h01, 3, 8'h20, 8'h40, 4};
        vecs[5]  = '{4'b0000, 8'hFF, 8'h01, 0, 8'h00, 8'h69, 1};
        vecs[6]  = '{4'b1000, 8'h00, 8'h01, 0, 8'hFF, 8'h64, 1};
        vecs[7]  = '{4'b1000, 8'h80, 8'h01, 0, 8'h7F, 8'h53, 1};
        vecs[8]  = '{4'b1001, 8'hAA, 8'hFF, 0, 8'h55, 8'h40, 1};
        vecs[9]  = '{4'b0010, 8'hF0, 8'h3C, 0, 8'h30, 8'h40, 1};
        vecs[10] = '{4'b0011, 8'h80, 8'h01, 0, 8'h81, 8'h64, 1};
        vecs[11] = '{4'b0101, 8'h00, 8'h03, 2, 8'h00, 8'h69, 3};
        vecs[12] = '{4'b0110, 8'h00, 8'h81, 7, 8'hC0, 8'h64, 8};
        vecs[13] = '{4'b0100, 8'h00, 8'h5A, 0, 8'h5A, 8'h40, 1};
        vecs[14] = '{4'b1101, 8'h00, 8'h80, 7, 8'h01, 8'h40, 8};

        // Reset, with a request offered while reset is held
        sel = 1'b0; rst = 1'b1; in_valid_t = 1'b0; out_ready_t = 1'b0;
        opcode_t = 4'd0; a_t = 32'd0; b_t = 32'd0; shamt_t = 4'd0;
        repeat (3) @(negedge clk);
        opcode_t = 4'b0000; a_t = 32'h7F; b_t = 32'h01; in_valid_t = 1'b1;
        @(negedge clk);
        check("rst result", cur_result, 32'h0);
        check("rst flags", 32'(cur_flags), 32'h40);
        check("rst out_valid", 32'(cur_out_valid), 32'd0);
        check("rst13 result", 32'(bus13.result), 32'h0);
        check("rst13 flags", 32'(bus13.flags), 32'h40);
        rst = 1'b0; in_valid_t = 1'b0;
        @(negedge clk);
        check("post-rst in_ready", 32'(cur_in_ready), 32'd1);
        check("post-rst out_valid", 32'(cur_out_valid), 32'd0);

        for (int i = 0; i < 15; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, 32'(vecs[i].a), 32'(vecs[i].b),
                   vecs[i].sh, 32'(vecs[i].r), vecs[i].f, vecs[i].lat);

        // Backpressure: DONE holds while new requests are offered
        @(negedge clk);
        opcode_t = 4'b0000; a_t = 32'h7F; b_t = 32'h01; in_valid_t = 1'b1;
        @(negedge clk);
        opcode_t = 4'b1000; a_t = 32'h11; b_t = 32'h22;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d out_valid", i), 32'(cur_out_valid), 32'd1);
            check($sformatf("bp%0d in_ready", i), 32'(cur_in_ready), 32'd0);
            check($sformatf("bp%0d result", i), cur_result, 32'h80);
            check($sformatf("bp%0d flags", i), 32'(cur_flags), 32'h66);
            @(negedge clk);
        end
        out_ready_t = 1'b1;
        @(negedge clk);
        out_ready_t = 1'b0;
        check("bp release out_valid", 32'(cur_out_valid), 32'd0);
        check("bp release in_ready", 32'(cur_in_ready), 32'd1);
        check("bp no second accept", cur_result, 32'h80);
        in_valid_t = 1'b0;

        // Reset during SHIFT aborts the operation
        @(negedge clk);
        opcode_t = 4'b0110; b_t = 32'h81; shamt_t = 4'd7; in_valid_t = 1'b1;
        @(negedge clk);
        in_valid_t = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort out_valid", 32'(cur_out_valid), 32'd0);
        check("abort in_ready", 32'(cur_in_ready), 32'd1);
        check("abort result", cur_result, 32'h0);
        check("abort flags", 32'(cur_flags), 32'h40);
        saw = 0;
        repeat (12) begin
            @(negedge clk);
            if (cur_out_valid) saw = 1;
        end
        check("abort no stale result", 32'(saw), 32'd0);

        // Randomised ops against the model at both widths
        for (int wi = 0; wi < 2; wi++) begin
            sel = (wi == 1);
            w   = sel ? 13 : 8;
            @(negedge clk);
            for (int n = 0; n < 150; n++) begin
                op = 4'($urandom);
                ra = $urandom;
                rb = $urandom;
                sh = $urandom_range(0, sel ? 15 : 7);
                model(w, op, ra, rb, sh, er, ef, el);
                run_op($sformatf("rnd w%0d #%0d op%0h", w, n, op), op, ra, rb, sh, er, ef, el);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
